// File: rtl/gp_reg_sequencer_if.sv
// Handshake and strobe bundle between a transfer requester and the GP register sequencer.
interface gp_reg_sequencer_if #(
    parameter int unsigned NREGS = 8
) ();
    localparam int unsigned SelW = $clog2(NREGS);

    logic             start;
    logic [1:0]       op;
    logic [SelW-1:0]  src;
    logic [SelW-1:0]  dst;
    logic             busy;
    logic             done;
    logic             err;
    logic [NREGS-1:0] notOE;
    logic [NREGS-1:0] notLoad;
    logic             extOE;
    logic             extLatch;

    modport master (
        output start, op, src, dst,
        input  busy, done, err, notOE, notLoad, extOE, extLatch
    );

    modport slave (
        input  start, op, src, dst,
        output busy, done, err, notOE, notLoad, extOE, extLatch
    );
endinterface

// File: rtl/gp_reg_sequencer.sv
// Sequences one bus transfer per request: drive for SETTLE_CYCLES, latch for one cycle, turn around.
// Every strobe is a flop so drivers and loads never glitch on the shared data bus.
module gp_reg_sequencer #(
    parameter int unsigned NREGS         = 8,
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic              clock,
    input  logic              notReset,
    gp_reg_sequencer_if.slave bus
);
    localparam int unsigned SelW    = $clog2(NREGS);
    localparam logic [2:0]  CntLoad = 3'(SETTLE_CYCLES - 1);

    localparam logic [1:0] OpMov     = 2'b00;
    localparam logic [1:0] OpLoad    = 2'b01;
    localparam logic [1:0] OpStore   = 2'b10;
    localparam logic [1:0] OpIllegal = 2'b11;

    typedef enum logic [1:0] {StIdle, StDrive, StLatch, StTurn} state_e;

    state_e           state_q;
    logic [1:0]       op_q;
    logic [SelW-1:0]  dst_q;
    logic [2:0]       cnt_q;
    logic [NREGS-1:0] not_oe_q;
    logic [NREGS-1:0] not_load_q;
    logic             ext_oe_q;
    logic             ext_latch_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    function automatic logic [NREGS-1:0] onehot(input logic [SelW-1:0] idx);
        logic [NREGS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state_q     <= StIdle;
            op_q        <= OpMov;
            dst_q       <= '0;
            cnt_q       <= '0;
            not_oe_q    <= '1;
            not_load_q  <= '1;
            ext_oe_q    <= 1'b0;
            ext_latch_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q  <= StDrive;
                        op_q     <= bus.op;
                        dst_q    <= bus.dst;
                        cnt_q    <= CntLoad;
                        busy_q   <= 1'b1;
                        ext_oe_q <= (bus.op == OpLoad);
                        // The source enable is the only use of src, so it is captured here directly.
                        if (bus.op == OpMov || bus.op == OpStore) begin
                            not_oe_q <= ~onehot(bus.src);
                        end
                    end
                end
                StDrive: begin
                    if (cnt_q == 3'd0) begin
                        state_q     <= StLatch;
                        ext_latch_q <= (op_q == OpStore);
                        if (op_q == OpMov || op_q == OpLoad) begin
                            not_load_q <= ~onehot(dst_q);
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                StLatch: begin
                    state_q     <= StTurn;
                    not_oe_q    <= '1;
                    not_load_q  <= '1;
                    ext_oe_q    <= 1'b0;
                    ext_latch_q <= 1'b0;
                    done_q      <= 1'b1;
                    err_q       <= (op_q == OpIllegal);
                end
                StTurn: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    err_q   <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.notOE    = not_oe_q;
    assign bus.notLoad  = not_load_q;
    assign bus.extOE    = ext_oe_q;
    assign bus.extLatch = ext_latch_q;
endmodule

// File: tb/tb_gp_reg_sequencer.sv
// Drives two sequencers (settle 1 and settle 3) against a bank model and a transfer-level reference.
module tb_gp_reg_sequencer;
    localparam int unsigned NREGS = 8;
    localparam logic [20:0] IdleVec = {3'b000, 8'hFF, 8'hFF, 2'b00};

    logic clock = 1'b0;
    logic notReset;
    always #5 clock = ~clock;

    gp_reg_sequencer_if #(.NREGS(NREGS)) b1 ();
    gp_reg_sequencer_if #(.NREGS(NREGS)) b3 ();

    gp_reg_sequencer #(.NREGS(NREGS), .SETTLE_CYCLES(1)) dut1 (
        .clock(clock), .notReset(notReset), .bus(b1.slave)
    );
    gp_reg_sequencer #(.NREGS(NREGS), .SETTLE_CYCLES(3)) dut3 (
        .clock(clock), .notReset(notReset), .bus(b3.slave)
    );

    logic        start, dsel;
    logic [1:0]  op;
    logic [2:0]  src, dst;
    logic [15:0] ext_src;

    assign b1.start = start & ~dsel;
    assign b3.start = start & dsel;
    assign b1.op = op;   assign b3.op = op;
    assign b1.src = src; assign b3.src = src;
    assign b1.dst = dst; assign b3.dst = dst;

    logic       busy, done, err, ext_oe, ext_latch;
    logic [7:0] noe, nload;
    assign busy      = dsel ? b3.busy     : b1.busy;
    assign done      = dsel ? b3.done     : b1.done;
    assign err       = dsel ? b3.err      : b1.err;
    assign noe       = dsel ? b3.notOE    : b1.notOE;
    assign nload     = dsel ? b3.notLoad  : b1.notLoad;
    assign ext_oe    = dsel ? b3.extOE    : b1.extOE;
    assign ext_latch = dsel ? b3.extLatch : b1.extLatch;

    logic [20:0] obs_vec;
    assign obs_vec = {busy, done, err, noe, nload, ext_oe, ext_latch};

    // Register bank and external sink, reacting only to the strobes.
    logic [15:0] regs [NREGS];
    logic [15:0] sink;
    logic [15:0] bus_val;
    always_comb begin
        bus_val = 16'hDEAD;
        for (int i = 0; i < NREGS; i++) if (!noe[i]) bus_val = regs[i];
        if (ext_oe) bus_val = ext_src;
    end
    always @(posedge clock) begin
        for (int i = 0; i < NREGS; i++) if (!nload[i]) regs[i] <= bus_val;
        if (ext_latch) sink <= bus_val;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Bus-safety invariants, every cycle.
    logic [7:0] prev_noe = 8'hFF;
    logic       prev_ext = 1'b0;
    always @(negedge clock) begin
        int  n_drv;
        bit  load_ok;
        n_drv   = $countones(~noe) + int'(ext_oe);
        load_ok = (nload == 8'hFF) ||
                  (prev_noe == noe && prev_ext == ext_oe && (noe != 8'hFF || ext_oe));
        chk("one_driver", 32'(n_drv <= 1), 32'd1);
        chk("one_load", 32'($countones(~nload) <= 1), 32'd1);
        chk("load_after_drive", 32'(load_ok), 32'd1);
        prev_noe = noe;
        prev_ext = ext_oe;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [15:0] ref_regs [NREGS];
    logic [15:0] ref_sink;
    bit          check_regs = 1'b0;

    // Expected strobe vector for cycle c after accept, from the phase rules alone.
    function automatic logic [20:0] exp_vec(int c, int s, logic [1:0] o, logic [2:0] sr,
                                            logic [2:0] ds);
        logic       b, d, e, xo, xl;
        logic [7:0] oe, ld;
        b = 0; d = 0; e = 0; xo = 0; xl = 0; oe = 8'hFF; ld = 8'hFF;
        if (c <= s + 2) b = 1;
        if (c >= 1 && c <= s + 1) begin
            if (o == 2'd0 || o == 2'd2) oe = ~(8'd1 << sr);
            if (o == 2'd1) xo = 1;
        end
        if (c == s + 1) begin
            if (o == 2'd0 || o == 2'd1) ld = ~(8'd1 << ds);
            if (o == 2'd2) xl = 1;
        end
        if (c == s + 2) begin
            d = 1;
            e = (o == 2'd3);
        end
        return {b, d, e, oe, ld, xo, xl};
    endfunction

    // Called just after a negedge with the selected sequencer idle.
    task automatic xfer(input logic [1:0] o, input logic [2:0] sr, input logic [2:0] ds,
                        input logic [15:0] ext, input bit hold, input bit pulse);
        int s;
        s = dsel ? 3 : 1;
        start = 1; op = o; src = sr; dst = ds; ext_src = ext;
        for (int c = 1; c <= s + 3; c++) begin
            @(negedge clock);
            chk($sformatf("xfer_s%0d_op%0d_c%0d", s, o, c), {11'd0, obs_vec},
                {11'd0, exp_vec(c, s, o, sr, ds)});
            if (c == 1) begin
                if (!hold) start = 0;
                op  = 2'($urandom);
                src = 3'($urandom);
                dst = 3'($urandom);
            end
            if (pulse && c == 2) start = 1;
            if (pulse && c == 3) start = 0;
        end
        if (pulse) begin
            @(negedge clock);
            chk("pulse_ignored", {30'd0, busy, done}, 32'd0);
        end
        case (o)
            2'd0: ref_regs[ds] = ref_regs[sr];
            2'd1: ref_regs[ds] = ext;
            2'd2: ref_sink = ref_regs[sr];
            default: ;
        endcase
        if (check_regs) begin
            for (int i = 0; i < NREGS; i++) chk($sformatf("reg%0d", i), 32'(regs[i]),
                                                32'(ref_regs[i]));
        end
        if (o == 2'd2) chk("sink", 32'(sink), 32'(ref_sink));
    endtask

    initial begin
        bit h, p;
        dsel = 0; start = 'x; op = 'x; src = 'x; dst = 'x; ext_src = 'x;
        notReset = 0;
        repeat (3) @(negedge clock);
        chk("reset_s1", {11'd0, obs_vec}, {11'd0, IdleVec});
        dsel = 1; #1;
        chk("reset_s3", {11'd0, obs_vec}, {11'd0, IdleVec});
        dsel = 0;
        start = 0; op = 0; src = 0; dst = 0; ext_src = 0;
        @(negedge clock);
        notReset = 1;
        @(negedge clock);
        chk("post_release", {11'd0, obs_vec}, {11'd0, IdleVec});

        for (int i = 0; i < NREGS; i++) xfer(2'd1, 3'd0, 3'(i), 16'($urandom), 0, 0);
        check_regs = 1;

        xfer(2'd1, 3'd0, 3'd2, 16'hBEEF, 0, 0);
        xfer(2'd0, 3'd2, 3'd5, 16'h0F0F, 0, 0);
        chk("mov_reg5", 32'(regs[5]), 32'h0000BEEF);
        xfer(2'd1, 3'd0, 3'd0, 16'h1234, 0, 0);
        chk("load_reg0", 32'(regs[0]), 32'h00001234);
        xfer(2'd1, 3'd0, 3'd7, 16'hA5A5, 0, 0);
        xfer(2'd2, 3'd7, 3'd3, 16'h5555, 0, 0);
        chk("store_sink", 32'(sink), 32'h0000A5A5);

        xfer(2'd0, 3'd1, 3'd6, 16'h0, 1, 0);
        xfer(2'd0, 3'd4, 3'd4, 16'h0, 0, 1);
        xfer(2'd3, 3'd2, 3'd3, 16'h0, 0, 0);

        // Abort a MOV during its latch cycle.
        xfer(2'd1, 3'd0, 3'd3, 16'h3333, 0, 0);
        xfer(2'd1, 3'd0, 3'd6, 16'h6666, 0, 0);
        start = 1; op = 2'd0; src = 3'd3; dst = 3'd6;
        @(negedge clock);
        start = 0;
        @(posedge clock);
        #2 notReset = 0;
        #1 chk("reset_mid_latch", {11'd0, obs_vec}, {11'd0, IdleVec});
        @(negedge clock);
        notReset = 1;
        repeat (4) begin
            @(negedge clock);
            chk("no_done_after_abort", {30'd0, busy, done}, 32'd0);
        end
        chk("abort_dst_unchanged", 32'(regs[6]), 32'h00006666);

        dsel = 1;
        xfer(2'd0, 3'd1, 3'd4, 16'h0, 0, 0);
        xfer(2'd0, 3'd5, 3'd2, 16'h0, 1, 0);
        xfer(2'd2, 3'd2, 3'd0, 16'h0, 0, 1);

        for (int k = 0; k < 30; k++) begin
            dsel = 1'($urandom);
            h = (k != 29) && 1'($urandom);
            p = !h && 1'($urandom);
            xfer(2'($urandom_range(0, 3)), 3'($urandom), 3'($urandom), 16'($urandom), h, p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
